// File: rtl/jtkiwi_obj_buf.sv
// Double-buffered object line buffer: the drawer fills one bank while the other is
// read out at pixel rate and erased behind the beam; banks swap at each HBLANK start.
module jtkiwi_obj_buf #(
    parameter int AW = 9,
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          LHBL,
    input  logic          LVBL,
    input  logic [AW-1:0] hdump,
    input  logic          flip,
    input  logic          buf_we,
    input  logic [AW-1:0] buf_addr,
    input  logic [DW-1:0] buf_din,
    output logic          line_start,
    output logic          init_done,
    output logic [DW-1:0] obj_pxl
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic { INIT, RUN } init_st_t;
    typedef enum logic [1:0] { IDLE, RD, CLR } rd_st_t;

    init_st_t      init_st_q, init_st_d;
    rd_st_t        rd_st_q, rd_st_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          lhbl_q, lhbl_d;
    logic          bank_q, bank_d;
    logic          line_start_q, line_start_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          rbank_q, rbank_d;
    logic [DW-1:0] pix_q, pix_d;
    logic [DW-1:0] obj_pxl_q, obj_pxl_d;

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];

    logic          running, hbl_fall, draw_we, clr_we;
    logic          we0, we1;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic [DW-1:0] rd_data;

    assign rd_data = rbank_q ? mem1[raddr_q] : mem0[raddr_q];

    always_comb begin
        init_st_d    = init_st_q;
        cnt_d        = cnt_q;
        rd_st_d      = rd_st_q;
        raddr_d      = raddr_q;
        rbank_d      = rbank_q;
        pix_d        = pix_q;
        obj_pxl_d    = obj_pxl_q;
        lhbl_d       = LHBL;

        running      = (init_st_q == RUN);
        hbl_fall     = lhbl_q & ~LHBL;
        bank_d       = bank_q ^ (running & hbl_fall);
        line_start_d = running & hbl_fall;

        if (init_st_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {AW{1'b1}}) init_st_d = RUN;
        end

        // The read bank is latched per access so a swap mid-access still clears the bank that was read.
        if (!running) begin
            rd_st_d = IDLE;
        end else begin
            case (rd_st_q)
                IDLE: if (pxl_cen && LHBL) begin
                    raddr_d = flip ? ~hdump : hdump;
                    rbank_d = bank_q;
                    rd_st_d = RD;
                end
                RD: begin
                    pix_d   = rd_data;
                    rd_st_d = CLR;
                end
                CLR:     rd_st_d = IDLE;
                default: rd_st_d = IDLE;
            endcase
        end

        // Blank flushes the pixel register so the next line never starts with a stale pixel.
        if (!running || !LHBL) pix_d = '0;

        if (!running) obj_pxl_d = '0;
        else if (pxl_cen) obj_pxl_d = (LHBL && LVBL) ? pix_q : '0;

        draw_we = running & buf_we & (buf_din[3:0] != 4'd0);
        clr_we  = running & (rd_st_q == CLR);

        we0 = 1'b0; wa0 = raddr_q; wd0 = '0;
        we1 = 1'b0; wa1 = raddr_q; wd1 = '0;
        if (!running) begin
            we0 = 1'b1; wa0 = cnt_q;
            we1 = 1'b1; wa1 = cnt_q;
        end else begin
            if (clr_we && !rbank_q) we0 = 1'b1;
            if (clr_we &&  rbank_q) we1 = 1'b1;
            if (draw_we && bank_q) begin
                we0 = 1'b1; wa0 = buf_addr; wd0 = buf_din;
            end
            if (draw_we && !bank_q) begin
                we1 = 1'b1; wa1 = buf_addr; wd1 = buf_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we0) mem0[wa0] <= wd0;
        if (we1) mem1[wa1] <= wd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_st_q    <= INIT;
            rd_st_q      <= IDLE;
            cnt_q        <= '0;
            lhbl_q       <= 1'b0;
            bank_q       <= 1'b0;
            line_start_q <= 1'b0;
            raddr_q      <= '0;
            rbank_q      <= 1'b0;
            pix_q        <= '0;
            obj_pxl_q    <= '0;
        end else begin
            init_st_q    <= init_st_d;
            rd_st_q      <= rd_st_d;
            cnt_q        <= cnt_d;
            lhbl_q       <= lhbl_d;
            bank_q       <= bank_d;
            line_start_q <= line_start_d;
            raddr_q      <= raddr_d;
            rbank_q      <= rbank_d;
            pix_q        <= pix_d;
            obj_pxl_q    <= obj_pxl_d;
        end
    end

    assign line_start = line_start_q;
    assign init_done  = (init_st_q == RUN);
    assign obj_pxl    = obj_pxl_q;
endmodule
